// File: rtl/sound_event_scheduler_if.sv
// Request/response bundle between the game FSM, the scheduler and the sound controller.
// The master drives the requests and the busy flag. The slave is the scheduler.
interface sound_event_scheduler_if;
  logic       evt_winrnd;
  logic       evt_wingame;
  logic       evt_speedrnd;
  logic       evt_winspeed;
  logic       snd_busy;
  logic       winrnd;
  logic       wingame;
  logic       speed_round;
  logic       winspeed;
  logic [3:0] pending;
  logic [3:0] drop_cnt;

  modport master (
    output evt_winrnd, evt_wingame, evt_speedrnd, evt_winspeed, snd_busy,
    input  winrnd, wingame, speed_round, winspeed, pending, drop_cnt
  );

  modport slave (
    input  evt_winrnd, evt_wingame, evt_speedrnd, evt_winspeed, snd_busy,
    output winrnd, wingame, speed_round, winspeed, pending, drop_cnt
  );
endinterface

// File: rtl/sound_event_scheduler.sv
// Queues edge-detected sound requests and issues them one at a time, in priority order.
// Each issue is followed by an ack/play phase and an enforced gap of slowen ticks.
module sound_event_scheduler #(
  parameter int GAP_TICKS   = 8,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   slowen,
  sound_event_scheduler_if.slave bus
);

  localparam int CNT_MAX = (GAP_TICKS > ACK_TIMEOUT) ? GAP_TICKS : ACK_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_TICKS - 1);
  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, PLAY, GAP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       evt_q, evt_d;
  logic [3:0]       pending_q, pending_d;
  logic [3:0]       pulse_q, pulse_d;
  logic [3:0]       drop_q, drop_d;

  logic [3:0] evt_rise;
  logic [3:0] issue_clr;
  logic [3:0] drop_hits;
  logic [2:0] drop_inc;
  logic [4:0] drop_sum;

  // Bit order everywhere is {wingame, winspeed, winrnd, speed_round}.
  assign evt_d    = {bus.evt_wingame, bus.evt_winspeed, bus.evt_winrnd, bus.evt_speedrnd};
  assign evt_rise = evt_d & ~evt_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pulse_d   = 4'b0000;
    issue_clr = 4'b0000;
    case (state_q)
      IDLE: begin
        if ((|pending_q) && !bus.snd_busy) begin
          state_d = ISSUE;
          if (pending_q[3])      pulse_d = 4'b1000;
          else if (pending_q[2]) pulse_d = 4'b0100;
          else if (pending_q[1]) pulse_d = 4'b0010;
          else                   pulse_d = 4'b0001;
          issue_clr = pulse_d;
        end
      end
      ISSUE: begin
        state_d = WAIT_ACK;
        cnt_d   = '0;
      end
      WAIT_ACK: begin
        if (bus.snd_busy) begin
          state_d = PLAY;
          cnt_d   = '0;
        end else if (slowen) begin
          if (cnt_q == ACK_LAST) begin
            state_d = GAP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      PLAY: begin
        if (!bus.snd_busy) begin
          state_d = GAP;
          cnt_d   = '0;
        end
      end
      GAP: begin
        if (slowen) begin
          if (cnt_q == GAP_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A new edge always wins over the issue clear or a game-over flush of the same bit.
  always_comb begin
    drop_hits = evt_rise & pending_q & ~issue_clr;
    drop_inc  = {2'b00, drop_hits[0]} + {2'b00, drop_hits[1]}
              + {2'b00, drop_hits[2]} + {2'b00, drop_hits[3]};
    drop_sum  = {1'b0, drop_q} + {2'b00, drop_inc};
    drop_d    = (drop_sum > 5'd15) ? 4'hF : drop_sum[3:0];
    pending_d = pending_q & ~issue_clr;
    if (evt_rise[3]) begin
      pending_d[2:0] = 3'b000;
    end
    pending_d = pending_d | evt_rise;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      evt_q     <= 4'b0000;
      pending_q <= 4'b0000;
      pulse_q   <= 4'b0000;
      drop_q    <= 4'b0000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      evt_q     <= evt_d;
      pending_q <= pending_d;
      pulse_q   <= pulse_d;
      drop_q    <= drop_d;
    end
  end

  assign bus.wingame     = pulse_q[3];
  assign bus.winspeed    = pulse_q[2];
  assign bus.winrnd      = pulse_q[1];
  assign bus.speed_round = pulse_q[0];
  assign bus.pending     = pending_q;
  assign bus.drop_cnt    = drop_q;

endmodule

// File: tb/tb_sound_event_scheduler.sv
// Bench for sound_event_scheduler: directed scenarios plus a randomized run
// compared cycle by cycle against a phase/countdown reference model.
module tb_sound_event_scheduler;
  localparam int GAP = 8;
  localparam int ACK = 4;
  localparam int M_READY = 0, M_ISSUED = 1, M_AWAIT = 2, M_PLAYING = 3, M_QUIET = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       slowen;
  logic       busy;
  logic [3:0] evt;
  logic [3:0] dut_pulse;

  sound_event_scheduler_if ifc();
  assign ifc.evt_wingame  = evt[3];
  assign ifc.evt_winspeed = evt[2];
  assign ifc.evt_winrnd   = evt[1];
  assign ifc.evt_speedrnd = evt[0];
  assign ifc.snd_busy     = busy;
  assign dut_pulse = {ifc.wingame, ifc.winspeed, ifc.winrnd, ifc.speed_round};

  sound_event_scheduler #(.GAP_TICKS(GAP), .ACK_TIMEOUT(ACK)) dut (
    .clk(clk), .rst(rst), .slowen(slowen), .bus(ifc.slave)
  );

  always #5 clk = ~clk;

  int         tests_run = 0;
  int         tests_failed = 0;
  int         cyc_n = 0;
  bit         slow_rand = 1'b0;
  bit         slow_hist[int];
  logic [3:0] pulse_log[$];

  logic [3:0] m_pend, m_prev, m_pulse, m_rise, m_taken, m_next;
  int         m_drop, m_phase, m_left;
  int         prio[4] = '{3, 2, 1, 0};

  // Reference: pending set + drop counter, and a sequencer counting slowen ticks down.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pend = 4'b0; m_prev = 4'b0; m_pulse = 4'b0; m_drop = 0; m_phase = M_READY; m_left = 0;
    end else begin
      m_rise  = evt & ~m_prev;
      m_prev  = evt;
      m_taken = 4'b0;
      case (m_phase)
        M_READY: if (m_pend != 4'b0 && !busy) begin
          foreach (prio[i]) if (m_taken == 4'b0 && m_pend[prio[i]]) m_taken[prio[i]] = 1'b1;
          m_phase = M_ISSUED;
        end
        M_ISSUED: begin m_phase = M_AWAIT; m_left = ACK; end
        M_AWAIT: if (busy) m_phase = M_PLAYING;
                 else if (slowen) begin
                   m_left--;
                   if (m_left == 0) begin m_phase = M_QUIET; m_left = GAP; end
                 end
        M_PLAYING: if (!busy) begin m_phase = M_QUIET; m_left = GAP; end
        default: if (slowen) begin
                   m_left--;
                   if (m_left == 0) m_phase = M_READY;
                 end
      endcase
      for (int i = 0; i < 4; i++)
        if (m_rise[i] && m_pend[i] && !m_taken[i] && m_drop < 15) m_drop++;
      m_next = m_pend & ~m_taken;
      if (m_rise[3]) m_next[2:0] = 3'b000;
      m_pend  = m_next | m_rise;
      m_pulse = m_taken;
    end
  end

  always @(negedge clk) if (rst && dut_pulse != 4'b0) pulse_log.push_back(dut_pulse);

  task automatic cycle();
    @(negedge clk);
    cyc_n++;
    slowen = slow_rand ? ($urandom_range(0, 2) == 0) : ((cyc_n % 4) == 0);
    slow_hist[cyc_n] = slowen;
  endtask

  task automatic run_until_idle(input int budget);
    int k = 0;
    while (!(m_phase == M_READY && m_pend == 4'b0) && k < budget) begin
      cycle();
      k++;
    end
    if (k >= budget) begin
      tests_run++; tests_failed++;
      $display("[TB] FAIL idle_wait: got %0d cycles, limit %0d", k, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; evt = 4'b0010; busy = 1'b0; slowen = 1'b0;
    repeat (3) cycle();
    tests_run++; if (dut_pulse !== 4'b0) begin tests_failed++; $display("[TB] FAIL rst_pulse: got %b want 0000", dut_pulse); end
    tests_run++; if (ifc.pending !== 4'b0) begin tests_failed++; $display("[TB] FAIL rst_pending: got %b want 0000", ifc.pending); end
    tests_run++; if (ifc.drop_cnt !== 4'b0) begin tests_failed++; $display("[TB] FAIL rst_drop: got %0d want 0", ifc.drop_cnt); end
    rst = 1'b1;
    cycle();
    tests_run++; if (ifc.pending !== 4'b0010) begin tests_failed++; $display("[TB] FAIL rel_pending: got %b want 0010", ifc.pending); end
    cycle();
    tests_run++; if (dut_pulse !== 4'b0010) begin tests_failed++; $display("[TB] FAIL rel_pulse: got %b want 0010", dut_pulse); end
    evt = 4'b0;
    cycle();
    tests_run++; if (dut_pulse !== 4'b0) begin tests_failed++; $display("[TB] FAIL rel_pulse_end: got %b want 0000", dut_pulse); end
  endtask

  task automatic test_single();
    logic [3:0] first;
    run_until_idle(400);
    pulse_log.delete();
    evt = 4'b0010;
    cycle();
    tests_run++; if (ifc.pending !== 4'b0010) begin tests_failed++; $display("[TB] FAIL single_pend: got %b want 0010", ifc.pending); end
    tests_run++; if (dut_pulse !== 4'b0) begin tests_failed++; $display("[TB] FAIL single_early: got %b want 0000", dut_pulse); end
    cycle();
    tests_run++; if (dut_pulse !== 4'b0010) begin tests_failed++; $display("[TB] FAIL single_pulse: got %b want 0010", dut_pulse); end
    tests_run++; if (ifc.pending !== 4'b0) begin tests_failed++; $display("[TB] FAIL single_clr: got %b want 0000", ifc.pending); end
    cycle();
    tests_run++; if (dut_pulse !== 4'b0) begin tests_failed++; $display("[TB] FAIL single_width: got %b want 0000", dut_pulse); end
    evt = 4'b0;
    run_until_idle(400);
    first = (pulse_log.size() > 0) ? pulse_log[0] : 4'b0;
    tests_run++; if (pulse_log.size() != 1 || first !== 4'b0010) begin
      tests_failed++; $display("[TB] FAIL single_count: got %0d pulses first %b want 1 of 0010", pulse_log.size(), first);
    end
  endtask

  task automatic test_priority();
    int n, q, ticks, guard;
    run_until_idle(400);
    evt = 4'b0101;
    cycle();
    tests_run++; if (ifc.pending !== 4'b0101) begin tests_failed++; $display("[TB] FAIL prio_pend: got %b want 0101", ifc.pending); end
    cycle();
    tests_run++; if (dut_pulse !== 4'b0100) begin tests_failed++; $display("[TB] FAIL prio_first: got %b want 0100", dut_pulse); end
    evt = 4'b0; busy = 1'b1;
    repeat (4) cycle();
    busy = 1'b0; n = cyc_n; guard = 0;
    do begin cycle(); guard++; end while (dut_pulse == 4'b0 && guard < 300);
    q = cyc_n; ticks = 0;
    for (int i = n + 1; i <= q - 2; i++) ticks += int'(slow_hist[i]);
    tests_run++; if (dut_pulse !== 4'b0001) begin tests_failed++; $display("[TB] FAIL prio_second: got %b want 0001", dut_pulse); end
    tests_run++; if (ticks != GAP) begin tests_failed++; $display("[TB] FAIL prio_gap: got %0d ticks want %0d", ticks, GAP); end
  endtask

  task automatic test_game_over();
    logic [3:0] first;
    run_until_idle(400);
    busy = 1'b1; evt = 4'b0011;
    cycle();
    evt = 4'b0;
    cycle();
    tests_run++; if (ifc.pending !== 4'b0011) begin tests_failed++; $display("[TB] FAIL go_setup: got %b want 0011", ifc.pending); end
    evt = 4'b1000;
    cycle();
    tests_run++; if (ifc.pending !== 4'b1000) begin tests_failed++; $display("[TB] FAIL go_flush: got %b want 1000", ifc.pending); end
    evt = 4'b0; busy = 1'b0;
    pulse_log.delete();
    run_until_idle(400);
    first = (pulse_log.size() > 0) ? pulse_log[0] : 4'b0;
    tests_run++; if (pulse_log.size() != 1 || first !== 4'b1000) begin
      tests_failed++; $display("[TB] FAIL go_issue: got %0d pulses first %b want 1 of 1000", pulse_log.size(), first);
    end
  endtask

  task automatic test_timeout();
    int p, q, ticks, guard;
    run_until_idle(400);
    evt = 4'b0011;
    cycle();
    evt = 4'b0;
    cycle();
    p = cyc_n;
    tests_run++; if (dut_pulse !== 4'b0010) begin tests_failed++; $display("[TB] FAIL to_first: got %b want 0010", dut_pulse); end
    guard = 0;
    do begin cycle(); guard++; end while (dut_pulse == 4'b0 && guard < 300);
    q = cyc_n; ticks = 0;
    for (int i = p + 1; i <= q - 2; i++) ticks += int'(slow_hist[i]);
    tests_run++; if (dut_pulse !== 4'b0001) begin tests_failed++; $display("[TB] FAIL to_second: got %b want 0001", dut_pulse); end
    tests_run++; if (ticks != ACK + GAP) begin tests_failed++; $display("[TB] FAIL to_ticks: got %0d want %0d", ticks, ACK + GAP); end
  endtask

  task automatic test_merge();
    logic [3:0] first;
    run_until_idle(400);
    busy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      evt = 4'b0010; cycle();
      evt = 4'b0;    cycle();
    end
    tests_run++; if (ifc.pending !== 4'b0010) begin tests_failed++; $display("[TB] FAIL merge_pend: got %b want 0010", ifc.pending); end
    tests_run++; if (ifc.drop_cnt !== 4'd15) begin tests_failed++; $display("[TB] FAIL merge_sat: got %0d want 15", ifc.drop_cnt); end
    busy = 1'b0;
    pulse_log.delete();
    run_until_idle(400);
    first = (pulse_log.size() > 0) ? pulse_log[0] : 4'b0;
    tests_run++; if (pulse_log.size() != 1 || first !== 4'b0010) begin
      tests_failed++; $display("[TB] FAIL merge_issue: got %0d pulses first %b want 1 of 0010", pulse_log.size(), first);
    end
  endtask

  task automatic test_reset_mid_gap();
    run_until_idle(400);
    evt = 4'b0100; cycle();
    evt = 4'b0;    cycle();
    busy = 1'b1; repeat (3) cycle();
    busy = 1'b0; repeat (2) cycle();
    evt = 4'b0011; cycle();
    evt = 4'b0;    cycle();
    tests_run++; if (ifc.pending !== 4'b0011) begin tests_failed++; $display("[TB] FAIL mid_pend: got %b want 0011", ifc.pending); end
    #2 rst = 1'b0;
    #1;
    tests_run++; if (dut_pulse !== 4'b0) begin tests_failed++; $display("[TB] FAIL mid_pulse: got %b want 0000", dut_pulse); end
    tests_run++; if (ifc.pending !== 4'b0) begin tests_failed++; $display("[TB] FAIL mid_clear: got %b want 0000", ifc.pending); end
    tests_run++; if (ifc.drop_cnt !== 4'b0) begin tests_failed++; $display("[TB] FAIL mid_drop: got %0d want 0", ifc.drop_cnt); end
    @(negedge clk);
    rst = 1'b1;
    pulse_log.delete();
    repeat (30) cycle();
    tests_run++; if (pulse_log.size() != 0) begin tests_failed++; $display("[TB] FAIL mid_quiet: got %0d pulses want 0", pulse_log.size()); end
    evt = 4'b1000; cycle();
    evt = 4'b0;    cycle();
    tests_run++; if (dut_pulse !== 4'b1000) begin tests_failed++; $display("[TB] FAIL mid_new: got %b want 1000", dut_pulse); end
  endtask

  task automatic test_random();
    int errs = 0;
    slow_rand = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 5) == 0) evt[i] = ~evt[i];
      if ($urandom_range(0, 7) == 0) busy = ~busy;
      cycle();
      tests_run++; if (dut_pulse !== m_pulse) begin tests_failed++; errs++;
        if (errs < 10) $display("[TB] FAIL rnd_pulse @%0d: got %b want %b", c, dut_pulse, m_pulse); end
      tests_run++; if (ifc.pending !== m_pend) begin tests_failed++; errs++;
        if (errs < 10) $display("[TB] FAIL rnd_pending @%0d: got %b want %b", c, ifc.pending, m_pend); end
      tests_run++; if (ifc.drop_cnt !== 4'(m_drop)) begin tests_failed++; errs++;
        if (errs < 10) $display("[TB] FAIL rnd_drop @%0d: got %0d want %0d", c, ifc.drop_cnt, m_drop); end
    end
  endtask

  initial begin
    rst = 1'b0; evt = 4'b0; busy = 1'b0; slowen = 1'b0;
    test_reset();
    test_single();
    test_priority();
    test_game_over();
    test_timeout();
    test_merge();
    test_reset_mid_gap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/sound_event_scheduler.md
SOUND_EVENT_SCHEDULER -- requirements
Module: sound_event_scheduler

Interface
REQ-001 Parameters (name, default, meaning): GAP_TICKS, 8, slowen ticks of silence enforced between issued events.
REQ-002 ACK_TIMEOUT, 4, slowen ticks to wait for snd_busy to rise after an issue.
REQ-003 Ports (name, direction, width, meaning): clk  in  1  system clock, single clock domain.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 slowen  in  1  one-cycle enable pulse at clk/256 (div256 output).
REQ-006 evt_winrnd, evt_wingame, evt_speedrnd, evt_winspeed  in  1 each  level requests from game FSM, may be held multiple cycles.
REQ-007 snd_busy  in  1  high while the sound controller is playing.
REQ-008 winrnd, wingame, speed_round, winspeed  out  1 each  one-cycle event pulses to the sound controller.
REQ-009 pending  out  4  queued requests {wingame, winspeed, winrnd, speed_round}, MSB first.
REQ-010 drop_cnt  out  4  saturating count of requests merged into an already-pending bit.

Function
REQ-011 Each evt_* SHALL be rising-edge detected against a registered copy; a detected edge sets its pending bit on the same clk edge.
REQ-012 A held-high evt_* SHALL produce exactly one request.
REQ-013 Edge on an already-set pending bit SHALL increment drop_cnt, saturating at 15; no second request.
REQ-014 Priority SHALL be wingame > winspeed > winrnd > speed_round.
REQ-015 A wingame edge SHALL clear the other three pending bits in the same cycle it sets its own.
REQ-016 Same-cycle set and clear of one pending bit: set SHALL win.
REQ-017 FSM states: IDLE, ISSUE, WAIT_ACK, PLAY, GAP.
REQ-018 IDLE: if pending != 0 and snd_busy = 0 -> ISSUE; else stay.
REQ-019 ISSUE (one cycle): assert output pulse of highest-priority pending bit, clear that bit, -> WAIT_ACK; exactly one output high.
REQ-020 WAIT_ACK: snd_busy = 1 -> PLAY; after ACK_TIMEOUT slowen ticks without busy -> GAP.
REQ-021 PLAY: snd_busy = 0 -> GAP.
REQ-022 GAP: count slowen ticks; on GAP_TICKS-th tick -> IDLE; counter cleared on entry.
REQ-023 Latency: evt sampled high at edge k with IDLE, snd_busy = 0, pending empty -> output high in cycle after edge k+1, for one cycle.
REQ-024 Outputs SHALL be registered; no combinational path from evt_* or snd_busy to outputs.
REQ-025 Requests arriving during ISSUE/WAIT_ACK/PLAY/GAP SHALL queue, not be lost except by merging per REQ-013.

Reset
REQ-026 rst low SHALL asynchronously force: all pulse outputs 0, pending 0, drop_cnt 0, edge registers 0, gap/timeout counters 0, state IDLE.
REQ-027 An evt_* already high at rst release SHALL count as one rising edge.
REQ-028 Reset mid-PLAY/GAP SHALL discard queue and sequence; no pulse in the cycle after release.

Verification
REQ-029 Single: evt_winrnd high 3 cycles, snd_busy 0 -> one winrnd pulse, 1 cycle wide, cycle after edge k+1; pending back to 0000.
REQ-030 Priority: evt_speedrnd and evt_winspeed rise same cycle -> winspeed issued first, speed_round only after PLAY end + 8 slowen ticks.
REQ-031 Game over: winrnd and speed_round pending, evt_wingame rises -> pending = 1000, only wingame issued.
REQ-032 Timeout: snd_busy held 0 after issue -> GAP entered after 4 slowen ticks, next pending issued after 8 more.
REQ-033 Merge/saturate: 17 evt_winrnd edges while snd_busy = 1 -> pending winrnd = 1, drop_cnt = 15, one pulse after busy falls and gap.
REQ-034 Reset mid-GAP with pending 0011 -> all outputs 0 immediately, pending 0000, no pulse until new edge.
